tw_rom4_seq_ctrl: RTL and testbench



---
 rtl/tw_rom4_seq_ctrl_if.sv | 25 ++
 rtl/tw_rom4_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tw_rom4_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tw_rom4_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// tw_rom4_seq_ctrl_if
//   Twiddle-reload stream from the FFT controller into the ROM sequencer.
//
//   Handshake: the source drives tw_valid and tw_data. It holds both stable
//   while tw_valid=1 and tw_ready=0. A word transfers on every rising clock
//   edge where tw_valid & tw_ready. tw_ready never depends on tw_valid.
//
//   Signals:
//     tw_valid  source -> sink  word present
//     tw_data   source -> sink  twiddle half-word (DW bits)
//     tw_ready  sink -> source  sink can take a word this cycle
//
//   Modports: master = source (controller), slave = sink (sequencer).
// ---------------------------------------------------------------------------
interface tw_rom4_seq_ctrl_if #(
  parameter int DW = 64
) ();
  logic          tw_valid;
  logic [DW-1:0] tw_data;
  logic          tw_ready;

  modport master (output tw_valid, output tw_data, input tw_ready);
  modport slave  (input tw_valid, input tw_data, output tw_ready);
endinterface

// File: rtl/tw_rom4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tw_rom4_seq_ctrl
//   Sequencer for the 4-entry radix-16 twiddle ROM. An optional reload runs
//   first. It collects 4 upper halves, then writes them as a gap-free burst
//   with code 1. It collects 4 lower halves, then writes them as a burst with
//   code 2. It then waits SETTLE_CYC cycles for the ROM's lower-half bypass
//   FIFO to drain. After that it runs NUM_STAGES stages of STAGE_CYC cycles
//   each with the ROM enabled, and pulses done.
//
// Ports:
//   CLK, rst            clock; asynchronous active-high reset
//   start, load_en      start request (IDLE only); load_en selects the reload
//   abort               synchronous abort back to IDLE, highest priority
//   tw                  reload stream (slave side of tw_rom4_seq_ctrl_if)
//   stage_counter       ROM stage select; 7 when not running
//   CEN                 ROM enable, active low
//   state               ROM state code; 4 in RUN, 0 otherwise
//   ROM4_w              0 none, 1 upper-half write, 2 lower-half write
//   horizontal_data_in  ROM write data; holds its value outside bursts
//   busy, done          FSM not idle; one-cycle completion pulse
//   fsm_state_dbg       raw FSM state register, for observation only
// ---------------------------------------------------------------------------
module tw_rom4_seq_ctrl #(
  parameter int DW         = 64,
  parameter int SC_WIDTH   = 3,
  parameter int S_WIDTH    = 4,
  parameter int ENTRIES    = 4,
  parameter int SETTLE_CYC = 13,
  parameter int STAGE_CYC  = 256,
  parameter int NUM_STAGES = 3
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                start,
  input  logic                load_en,
  input  logic                abort,
  tw_rom4_seq_ctrl_if.slave   tw,
  output logic [SC_WIDTH-1:0] stage_counter,
  output logic                CEN,
  output logic [S_WIDTH-1:0]  state,
  output logic [1:0]          ROM4_w,
  output logic [DW-1:0]       horizontal_data_in,
  output logic                busy,
  output logic                done,
  output logic [2:0]          fsm_state_dbg
);

  localparam int WW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CYC_MX = (STAGE_CYC > SETTLE_CYC) ? STAGE_CYC : SETTLE_CYC;
  localparam int CW     = (CYC_MX > 1) ? $clog2(CYC_MX) : 1;

  localparam logic [WW-1:0]       LAST_ENTRY = WW'(ENTRIES - 1);
  localparam logic [CW-1:0]       SETTLE_TC  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]       STAGE_TC   = CW'(STAGE_CYC - 1);
  localparam logic [SC_WIDTH-1:0] LAST_STAGE = SC_WIDTH'(NUM_STAGES - 1);
  localparam logic [SC_WIDTH-1:0] SC_IDLE    = SC_WIDTH'(7);
  localparam logic [S_WIDTH-1:0]  ST_RUN     = S_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_HI  = 3'd1,
    BURST_HI = 3'd2,
    LOAD_LO  = 3'd3,
    BURST_LO = 3'd4,
    SETTLE   = 3'd5,
    RUN      = 3'd6,
    DONE     = 3'd7
  } fsm_t;

  fsm_t          fsm_q;
  logic [WW-1:0] wcnt_q;   // next buffer slot to fill
  logic [WW-1:0] bcnt_q;   // burst word currently on the ROM port
  logic [CW-1:0] cyc_q;    // settle / stage cycle counter
  logic [DW-1:0] tw_buf [ENTRIES];

  logic accept;

  // tw_ready is the only output decoded straight from the state register.
  assign tw.tw_ready   = (fsm_q == LOAD_HI) || (fsm_q == LOAD_LO);
  assign accept        = tw.tw_valid && tw.tw_ready;
  assign fsm_state_dbg = fsm_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      fsm_q              <= IDLE;
      wcnt_q             <= '0;
      bcnt_q             <= '0;
      cyc_q              <= '0;
      stage_counter      <= SC_IDLE;
      CEN                <= 1'b1;
      state              <= '0;
      ROM4_w             <= 2'd0;
      horizontal_data_in <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) tw_buf[i] <= '0;
    end else if (abort) begin
      // The buffer and horizontal_data_in are left alone on purpose. A word
      // handed over in this cycle is dropped.
      fsm_q         <= IDLE;
      wcnt_q        <= '0;
      bcnt_q        <= '0;
      cyc_q         <= '0;
      stage_counter <= SC_IDLE;
      CEN           <= 1'b1;
      state         <= '0;
      ROM4_w        <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (load_en) begin
              fsm_q <= LOAD_HI;
            end else begin
              fsm_q         <= RUN;
              cyc_q         <= '0;
              CEN           <= 1'b0;
              stage_counter <= '0;
              state         <= ST_RUN;
            end
          end
        end

        LOAD_HI, LOAD_LO: begin
          if (accept) begin
            tw_buf[wcnt_q] <= tw.tw_data;
            wcnt_q         <= wcnt_q + 1'b1;
            if (wcnt_q == LAST_ENTRY) begin
              // Entry 0 goes out on the next cycle. The write to the last
              // slot lands in the same edge, so it is not needed until k=3.
              fsm_q              <= (fsm_q == LOAD_HI) ? BURST_HI : BURST_LO;
              ROM4_w             <= (fsm_q == LOAD_HI) ? 2'd1 : 2'd2;
              horizontal_data_in <= tw_buf[0];
              bcnt_q             <= '0;
            end
          end
        end

        BURST_HI, BURST_LO: begin
          bcnt_q <= bcnt_q + 1'b1;
          if (bcnt_q == LAST_ENTRY) begin
            ROM4_w <= 2'd0;
            fsm_q  <= (fsm_q == BURST_HI) ? LOAD_LO : SETTLE;
            cyc_q  <= '0;
          end else begin
            horizontal_data_in <= tw_buf[bcnt_q + 1'b1];
          end
        end

        SETTLE: begin
          if (cyc_q == SETTLE_TC) begin
            cyc_q         <= '0;
            fsm_q         <= RUN;
            CEN           <= 1'b0;
            stage_counter <= '0;
            state         <= ST_RUN;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        RUN: begin
          if (cyc_q == STAGE_TC) begin
            cyc_q <= '0;
            if (stage_counter == LAST_STAGE) begin
              fsm_q         <= DONE;
              CEN           <= 1'b1;
              stage_counter <= SC_IDLE;
              state         <= '0;
              done          <= 1'b1;
            end else begin
              stage_counter <= stage_counter + 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          fsm_q <= IDLE;
        end

        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tw_rom4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tw_rom4_seq_ctrl
//   Self-checking bench for tw_rom4_seq_ctrl. The drivers push the expected
//   ROM-side trace of each sequence into exp_q when they issue start. The
//   monitor runs on every falling edge. In every cycle where the DUT is busy
//   and not taking words, it pops one expected entry and compares. In every
//   other cycle it checks the idle output values.
// ---------------------------------------------------------------------------
module tb_tw_rom4_seq_ctrl;

  localparam int DW         = 64;
  localparam int SC_WIDTH   = 3;
  localparam int S_WIDTH    = 4;
  localparam int ENTRIES    = 4;
  localparam int SETTLE_CYC = 13;
  localparam int STAGE_CYC  = 256;
  localparam int NUM_STAGES = 3;

  typedef struct packed {
    logic [1:0]          w;
    logic [DW-1:0]       data;
    logic                cen;
    logic [SC_WIDTH-1:0] sc;
    logic [S_WIDTH-1:0]  st;
    logic                done;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  logic                start, load_en, abort;
  logic [SC_WIDTH-1:0] stage_counter;
  logic                CEN;
  logic [S_WIDTH-1:0]  state;
  logic [1:0]          ROM4_w;
  logic [DW-1:0]       horizontal_data_in;
  logic                busy, done;
  logic [2:0]          fsm_state_dbg;

  tw_rom4_seq_ctrl_if #(.DW(DW)) tw_if ();

  tw_rom4_seq_ctrl #(
    .DW(DW), .SC_WIDTH(SC_WIDTH), .S_WIDTH(S_WIDTH), .ENTRIES(ENTRIES),
    .SETTLE_CYC(SETTLE_CYC), .STAGE_CYC(STAGE_CYC), .NUM_STAGES(NUM_STAGES)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .load_en(load_en), .abort(abort),
    .tw(tw_if), .stage_counter(stage_counter), .CEN(CEN), .state(state),
    .ROM4_w(ROM4_w), .horizontal_data_in(horizontal_data_in),
    .busy(busy), .done(done), .fsm_state_dbg(fsm_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [OBS_W-1:0] exp_q[$];
  logic [DW-1:0]    exp_last_data;
  logic             exp_busy;
  logic             mon_en;
  int               checks = 0;
  int               errors = 0;
  logic [DW-1:0]    words [2*ENTRIES];

  function automatic obs_t mk_obs(logic [1:0] w, logic [DW-1:0] d, logic cen,
                                  logic [SC_WIDTH-1:0] sc, logic [S_WIDTH-1:0] st,
                                  logic dn);
    obs_t o;
    o.w = w; o.data = d; o.cen = cen; o.sc = sc; o.st = st; o.done = dn;
    return o;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: the complete ROM-side trace of one sequence, built from
  // the behaviour list of the block. Data is don't-care (0) when w=0. The
  // monitor substitutes the held write value there.
  task automatic model_push(input logic with_load);
    if (with_load) begin
      for (int k = 0; k < ENTRIES; k++)
        exp_q.push_back(mk_obs(2'd1, words[k], 1'b1, 3'd7, 4'd0, 1'b0));
      for (int k = 0; k < ENTRIES; k++)
        exp_q.push_back(mk_obs(2'd2, words[ENTRIES+k], 1'b1, 3'd7, 4'd0, 1'b0));
      for (int k = 0; k < SETTLE_CYC; k++)
        exp_q.push_back(mk_obs(2'd0, '0, 1'b1, 3'd7, 4'd0, 1'b0));
    end
    for (int i = 0; i < NUM_STAGES * STAGE_CYC; i++)
      exp_q.push_back(mk_obs(2'd0, '0, 1'b0, SC_WIDTH'(i / STAGE_CYC), 4'd4, 1'b0));
    exp_q.push_back(mk_obs(2'd0, '0, 1'b1, 3'd7, 4'd0, 1'b1));
  endtask

  // ---------------- monitor ----------------
  initial begin
    obs_t act, e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        act = mk_obs(ROM4_w, horizontal_data_in, CEN, stage_counter, state, done);
        if (busy && !tw_if.tw_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_active actual=%h required=nothing", act);
          end else begin
            e = obs_t'(exp_q.pop_front());
            if (e.w == 2'd0) e.data = exp_last_data;
            if (act !== e) begin
              errors++;
              $display("FAIL rom_trace actual=%h required=%h", act, e);
            end
            exp_last_data = e.data;
            if (e.done) exp_busy = 1'b0;
          end
        end else begin
          e = mk_obs(2'd0, exp_last_data, 1'b1, 3'd7, 4'd0, 1'b0);
          checks++;
          if (act !== e || busy !== exp_busy) begin
            errors++;
            $display("FAIL idle_outputs actual=%h busy=%b required=%h busy=%b",
                     act, busy, e, exp_busy);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic issue_start(input logic le);
    start = 1'b1; load_en = le;
    @(posedge CLK); #1;
    start = 1'b0; load_en = 1'b0;
    exp_busy = 1'b1;
  endtask

  task automatic poke_start();
    start = 1'b1; load_en = 1'($urandom_range(0, 1));
    @(posedge CLK); #1;
    start = 1'b0; load_en = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int gap);
    logic r, got;
    int   n;
    tw_if.tw_valid = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
    tw_if.tw_valid = 1'b1; tw_if.tw_data = d;
    got = 1'b0; n = 0;
    while (!got && n < 100) begin
      @(negedge CLK); r = tw_if.tw_ready;
      @(posedge CLK); #1;
      got = r; n++;
    end
    tw_if.tw_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL word_accept actual=not_accepted required=accepted data=%h", d);
    end
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return $urandom_range(0, 3);
  endfunction

  task automatic rand_words();
    for (int i = 0; i < 2*ENTRIES; i++) words[i] = {$urandom, $urandom};
  endtask

  task automatic load_seq(input int mode);
    model_push(1'b1);
    issue_start(1'b1);
    for (int i = 0; i < 2*ENTRIES; i++) send_word(words[i], gap_for(mode));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_busy) && n < 3000) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL completion_timeout actual=pending_%0d required=0", exp_q.size());
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0; tw_if.tw_valid = 1'b0;
    exp_q.delete();
    exp_busy = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; load_en = 1'b0; abort = 1'b0;
    tw_if.tw_valid = 1'b0; tw_if.tw_data = '0;
    mon_en = 1'b0; exp_busy = 1'b0; exp_last_data = '0;

    // Reset values
    repeat (2) @(posedge CLK); #1;
    chk("rst_stage_counter", DW'(stage_counter), 64'd7);
    chk("rst_cen", DW'(CEN), 64'd1);
    chk("rst_state", DW'(state), 64'd0);
    chk("rst_rom4_w", DW'(ROM4_w), 64'd0);
    chk("rst_hdata", horizontal_data_in, 64'd0);
    chk("rst_busy", DW'(busy), 64'd0);
    chk("rst_done", DW'(done), 64'd0);
    chk("rst_tw_ready", DW'(tw_if.tw_ready), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end

    // Full load, tw_valid held high, fixed words
    for (int k = 0; k < ENTRIES; k++) begin
      words[k]         = DW'(8'h10 + k);
      words[ENTRIES+k] = DW'(8'h20 + k);
    end
    load_seq(0);
    wait_idle();

    // Gappy source: tw_valid toggling 1/0
    rand_words();
    load_seq(1);
    wait_idle();

    // Random gaps
    rand_words();
    load_seq(2);
    wait_idle();

    // Straight to RUN
    model_push(1'b0);
    issue_start(1'b0);
    chk("run_cen_next", DW'(CEN), 64'd0);
    chk("run_sc_next", DW'(stage_counter), 64'd0);
    wait_idle();

    // Abort at RUN cycle 300 (stage_counter=1)
    model_push(1'b0);
    issue_start(1'b0);
    repeat (300) begin @(posedge CLK); #1; end
    chk("abort_pre_sc", DW'(stage_counter), 64'd1);
    do_abort();
    chk("abort_cen", DW'(CEN), 64'd1);
    chk("abort_sc", DW'(stage_counter), 64'd7);
    chk("abort_busy", DW'(busy), 64'd0);
    chk("abort_done", DW'(done), 64'd0);
    repeat (5) begin @(posedge CLK); #1; end

    // Abort during LOAD_HI with a word offered in the abort cycle, then reload
    rand_words();
    model_push(1'b1);
    issue_start(1'b1);
    send_word(words[0], 0);
    send_word(words[1], 1);
    tw_if.tw_valid = 1'b1; tw_if.tw_data = {$urandom, $urandom};
    do_abort();
    repeat (3) begin @(posedge CLK); #1; end
    rand_words();
    load_seq(2);
    wait_idle();

    // start pulsed during LOAD_LO and during RUN is ignored
    rand_words();
    model_push(1'b1);
    issue_start(1'b1);
    for (int i = 0; i < ENTRIES + 1; i++) send_word(words[i], 0);
    poke_start();
    for (int i = ENTRIES + 1; i < 2*ENTRIES; i++) send_word(words[i], gap_for(2));
    repeat (40) begin @(posedge CLK); #1; end
    poke_start();
    wait_idle();
    repeat (10) begin @(posedge CLK); #1; end

    // start together with abort in IDLE is ignored
    start = 1'b1; load_en = 1'b1; abort = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; load_en = 1'b0; abort = 1'b0;
    chk("start_abort_busy", DW'(busy), 64'd0);
    repeat (5) begin @(posedge CLK); #1; end

    // Reset asserted mid-RUN takes effect immediately
    model_push(1'b0);
    issue_start(1'b0);
    repeat (100) begin @(posedge CLK); #1; end
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_stage_counter", DW'(stage_counter), 64'd7);
    chk("midrst_cen", DW'(CEN), 64'd1);
    chk("midrst_state", DW'(state), 64'd0);
    chk("midrst_rom4_w", DW'(ROM4_w), 64'd0);
    chk("midrst_hdata", horizontal_data_in, 64'd0);
    chk("midrst_busy", DW'(busy), 64'd0);
    chk("midrst_done", DW'(done), 64'd0);
    exp_q.delete();
    exp_busy = 1'b0;
    exp_last_data = '0;
    @(posedge CLK); #3;
    rst = 1'b0;
    @(posedge CLK); #1;
    mon_en = 1'b1;
    chk("post_rst_busy", DW'(busy), 64'd0);
    chk("post_rst_ready", DW'(tw_if.tw_ready), 64'd0);
    repeat (5) begin @(posedge CLK); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
